// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, default line parameters and baud helpers
// shared by the UART receiver and transmitter.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam int DEF_CLK_SPEED = 12000000;
    localparam int DEF_BAUD_RATE = 19200;
    function automatic int baud_count(input int clk_speed, input int baud_rate);
        return clk_speed / baud_rate;
    endfunction
    function automatic int cnt_width(input int clk_speed, input int baud_rate);
        return $clog2(baud_count(clk_speed, baud_rate) + 1);
    endfunction
endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for an asynchronous pin, resetting to
// the idle-high line level.
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic s1_q, s2_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end
    assign q = s2_q;
endmodule

// File: rtl/uartrx.sv
// uartrx: 8N1 UART receiver sampling mid-bit, with one-cycle valid/error strobes.
// Define UARTRX_MAJORITY_EN to take a 3-sample majority vote at each sample point.
import uart_pkg::*;

module uartrx #(
    parameter int CLK_SPEED = DEF_CLK_SPEED,
    parameter int BAUD_RATE = DEF_BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_error,
    output logic       rx_busy
);
    localparam int BAUD_COUNT = baud_count(CLK_SPEED, BAUD_RATE);
    localparam int HALF       = BAUD_COUNT / 2;
    localparam int CW         = cnt_width(CLK_SPEED, BAUD_RATE);

    logic          rx_s, smp, tick_half, tick_full;
    logic          rx_dly_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d, byte_q, byte_d;
    logic          valid_q, valid_d, err_q, err_d;

    uart_sync u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));

`ifdef UARTRX_MAJORITY_EN
    // Two stored samples plus the current one form the three-clock window.
    logic [1:0] hist_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hist_q <= 2'b11;
        else      hist_q <= {hist_q[0], rx_s};
    end
    assign smp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign smp = rx_s;
`endif

    assign tick_half = cnt_q == CW'(HALF - 1);
    assign tick_full = cnt_q == CW'(BAUD_COUNT - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == IDLE) ? '0 : cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (rx_dly_q && !rx_s) begin
                state_d = START;
                cnt_d   = '0;
            end
            START: if (tick_half) begin
                state_d = smp ? IDLE : DATA;
                cnt_d   = '0;
                idx_d   = '0;
            end
            DATA: if (tick_full) begin
                shift_d[idx_q] = smp;
                idx_d          = idx_q + 3'd1;
                cnt_d          = '0;
                state_d        = (idx_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (tick_full) begin
                state_d = IDLE;
                cnt_d   = '0;
                valid_d = smp;
                err_d   = !smp;
                byte_d  = smp ? shift_q : byte_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            rx_dly_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            rx_dly_q <= rx_s;
        end
    end

    assign rx_byte  = byte_q;
    assign rx_valid = valid_q;
    assign rx_error = err_q;
    assign rx_busy  = state_q != IDLE;
endmodule

// File: tb/tb_uartrx.sv
// tb_uartrx: directed frames on a 16-clock-per-bit receiver plus one frame on a
// default-parameter instance, with strobe counters kept by negedge monitors.
module tb_uartrx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx2 = 1'b1;
    logic [7:0] rx_byte, rx_byte2;
    logic       rx_valid, rx_error, rx_busy, rx_valid2, rx_error2, rx_busy2;
    int         total = 0, bad = 0;
    int         vcnt = 0, ecnt = 0, both_cnt = 0, vcnt2 = 0, ecnt2 = 0;
    logic [7:0] v_byte = 8'h00, e_byte = 8'h00, v_byte2 = 8'h00;

    uartrx #(.CLK_SPEED(16), .BAUD_RATE(1)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_byte(rx_byte),
        .rx_valid(rx_valid), .rx_error(rx_error), .rx_busy(rx_busy)
    );

    uartrx dut_def (
        .clk(clk), .rst(rst), .rx(rx2), .rx_byte(rx_byte2),
        .rx_valid(rx_valid2), .rx_error(rx_error2), .rx_busy(rx_busy2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin vcnt++; v_byte = rx_byte; end
        if (rx_error) begin ecnt++; e_byte = rx_byte; end
        if (rx_valid && rx_error) both_cnt++;
        if (rx_valid2) begin vcnt2++; v_byte2 = rx_byte2; end
        if (rx_error2) ecnt2++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // One 160-clock frame; optional one-clock high glitch and a reset held to frame end.
    task automatic drive_frame(input logic [7:0] b, input logic stop, input int glitch_at, input int rst_at);
        for (int c = 0; c < 160; c++) begin
            int p;
            logic v;
            p = c / 16;
            v = (p == 0) ? 1'b0 : (p <= 8) ? b[p-1] : stop;
            if (c == glitch_at) v = 1'b1;
            rx = v;
            if (c == rst_at) rst = 1'b0;
            if (c == 159 && rst_at >= 0) rst = 1'b1;
            @(posedge clk); #1;
            if (c == rst_at) chk("outputs_in_reset", {rx_byte, rx_valid, rx_error, rx_busy}, 32'h0);
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("reset_outputs", {rx_byte, rx_valid, rx_error, rx_busy}, 32'h0);
        rst = 1'b1;
        idle(5);

        drive_frame(8'hA5, 1'b1, -1, -1);
        idle(16);
        chk("a5_count", vcnt, 1);
        chk("a5_byte", v_byte, 8'hA5);
        chk("a5_no_err", ecnt, 0);
        chk("a5_busy_low", rx_busy, 1'b0);

        drive_frame(8'h00, 1'b1, -1, -1);
        chk("b2b_first", v_byte, 8'h00);
        drive_frame(8'hFF, 1'b1, -1, -1);
        idle(16);
        chk("b2b_second", v_byte, 8'hFF);
        chk("b2b_count", vcnt, 3);

        rx = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rx = 1'b1;
        chk("glitch_busy_high", rx_busy, 1'b1);
        repeat (8) begin @(posedge clk); #1; end
        chk("glitch_busy_low", rx_busy, 1'b0);
        idle(20);
        chk("glitch_no_valid", vcnt, 3);
        chk("glitch_no_err", ecnt, 0);

        drive_frame(8'h55, 1'b0, -1, -1);
        rx = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        chk("break_one_err", ecnt, 1);
        chk("break_byte_held", e_byte, 8'hFF);
        chk("break_busy_low", rx_busy, 1'b0);
        idle(20);
        chk("break_no_valid", vcnt, 3);
        drive_frame(8'h3C, 1'b1, -1, -1);
        idle(16);
        chk("after_break_byte", v_byte, 8'h3C);
        chk("after_break_count", vcnt, 4);
        chk("after_break_err", ecnt, 1);

        drive_frame(8'h81, 1'b1, -1, 88);
        idle(20);
        chk("reset_abort_count", vcnt, 4);
        chk("reset_byte_cleared", rx_byte, 8'h00);
        drive_frame(8'h42, 1'b1, -1, -1);
        idle(16);
        chk("after_reset_byte", v_byte, 8'h42);
        chk("after_reset_count", vcnt, 5);

        drive_frame(8'h00, 1'b1, 56, -1);
        idle(16);
        chk("vote_count", vcnt, 6);
`ifdef UARTRX_MAJORITY_EN
        chk("vote_byte", v_byte, 8'h00);
`else
        chk("vote_byte", v_byte, 8'h04);
`endif
        chk("never_both", both_cnt, 0);
        chk("total_err", ecnt, 1);

        for (int c = 0; c < 6250; c++) begin
            int p;
            logic [7:0] b;
            b = 8'h3C;
            p = c / 625;
            rx2 = (p == 0) ? 1'b0 : (p <= 8) ? b[p-1] : 1'b1;
            @(posedge clk); #1;
        end
        rx2 = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        chk("default_byte", v_byte2, 8'h3C);
        chk("default_count", vcnt2, 1);
        chk("default_no_err", ecnt2, 0);
        chk("default_busy_low", rx_busy2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
